// File: rtl/text_mode_renderer.sv
// text_mode_renderer
//
// Turns the VGA scan position into 1-bit-per-channel RGB for an 80x30 text
// screen of 8x16 glyphs (640x480). A three-stage pixel pipeline, advanced
// only on clkDiv, fetches the character/attribute word from an external
// character RAM, then the glyph row from an external font ROM, then forms
// the pixel. Raw syncs travel through the same three stages so they stay
// aligned with the pixel data at the connector.
//
// Ports:
//   clk, rst          system clock, synchronous active-low reset
//   clkDiv            pixel enable (one clk cycle high per pixel)
//   row, column       scan position from VgaController
//   displayActive     active-video flag from VgaController
//   hSync, vSync      raw syncs (active low)
//   charAddr/charData character RAM read port (1-clk latency)
//   fontAddr/fontData font ROM read port (1-clk latency), bit 7 = leftmost
//   cursorRow/Col/En  cursor position and enable, sampled at the last stage
//   red, green, blue  pixel colour
//   hSyncOut/vSyncOut syncs delayed to match the pixel pipeline
module text_mode_renderer #(
    parameter int COLS      = 80,
    parameter int ROWS      = 30,
    parameter int BLINK_BIT = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clkDiv,
    input  logic [8:0]  row,
    input  logic [9:0]  column,
    input  logic        displayActive,
    input  logic        hSync,
    input  logic        vSync,
    output logic [11:0] charAddr,
    input  logic [15:0] charData,
    output logic [11:0] fontAddr,
    input  logic [7:0]  fontData,
    input  logic [4:0]  cursorRow,
    input  logic [6:0]  cursorCol,
    input  logic        cursorEn,
    output logic        red,
    output logic        green,
    output logic        blue,
    output logic        hSyncOut,
    output logic        vSyncOut
);

    // Stage-0 side data
    logic [3:0] glyph_row_p0;
    logic [2:0] px_p0;
    logic [4:0] cell_row_p0;
    logic [6:0] cell_col_p0;
    logic       vld_p0;
    logic       hsync_p0;
    logic       vsync_p0;

    // Stage-1 side data and attributes
    logic [3:0] glyph_row_p1;
    logic [2:0] px_p1;
    logic [4:0] cell_row_p1;
    logic [6:0] cell_col_p1;
    logic       vld_p1;
    logic       hsync_p1;
    logic       vsync_p1;
    logic [2:0] fg_p1;
    logic [2:0] bg_p1;
    logic       blink_p1;

    logic [5:0] frame_count;

    // Stage-2 combinational result
    logic       blink_phase;
    logic       pixel_bit;
    logic       cursor_in_range;
    logic       cursor_hit;
    logic [2:0] fg_eff;
    logic [2:0] rgb_next;

    // Bit 15 of the character word carries nothing.
    logic unused_char_bit;
    assign unused_char_bit = charData[15];

    // row*80 + col built from shifts: (r<<6) + (r<<4) + c, 12 bits wide.
    function automatic logic [11:0] cell_addr(input logic [4:0] r, input logic [6:0] c);
        logic [11:0] r_w;
        r_w = {7'd0, r};
        return (r_w << 6) + (r_w << 4) + {5'd0, c};
    endfunction

    always_comb begin
        blink_phase     = frame_count[BLINK_BIT];
        pixel_bit       = fontData[3'd7 - px_p1];
        cursor_in_range = (int'(cursorRow) < ROWS) && (int'(cursorCol) < COLS);
        // Underline cursor occupies the bottom two glyph rows (14 and 15).
        cursor_hit      = cursorEn && blink_phase && cursor_in_range &&
                          (cursorRow == cell_row_p1) && (cursorCol == cell_col_p1) &&
                          (glyph_row_p1[3:1] == 3'b111);
        fg_eff          = (blink_p1 && blink_phase) ? bg_p1 : fg_p1;
        rgb_next        = 3'b000;
        if (vld_p1) begin
            rgb_next = (pixel_bit || cursor_hit) ? fg_eff : bg_p1;
        end
    end

    // Control, addresses and outputs: reset values are visible immediately.
    always_ff @(posedge clk) begin
        if (!rst) begin
            charAddr    <= 12'd0;
            fontAddr    <= 12'd0;
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            hsync_p0    <= 1'b1;
            hsync_p1    <= 1'b1;
            vsync_p0    <= 1'b1;
            vsync_p1    <= 1'b1;
            red         <= 1'b0;
            green       <= 1'b0;
            blue        <= 1'b0;
            hSyncOut    <= 1'b1;
            vSyncOut    <= 1'b1;
            frame_count <= 6'd0;
        end else if (clkDiv) begin
            // ---- stage 0: character RAM address, sample scan position
            if (displayActive) begin
                charAddr <= cell_addr(row[8:4], column[9:3]);
            end
            vld_p0   <= displayActive;
            hsync_p0 <= hSync;
            vsync_p0 <= vSync;
            // vSync falling edge seen across consecutive pixel samples
            if (vsync_p0 && !vSync) begin
                frame_count <= frame_count + 6'd1;
            end
            // ---- stage 1: font ROM address from the returned character code
            fontAddr <= {charData[7:0], glyph_row_p0};
            vld_p1   <= vld_p0;
            hsync_p1 <= hsync_p0;
            vsync_p1 <= vsync_p0;
            // ---- stage 2: pixel colour and aligned syncs
            {red, green, blue} <= rgb_next;
            hSyncOut <= hsync_p1;
            vSyncOut <= vsync_p1;
        end
    end

    // Data side registers need no reset: vld_pN blanks anything stale.
    always_ff @(posedge clk) begin
        if (clkDiv) begin
            // ---- stage 0
            glyph_row_p0 <= row[3:0];
            px_p0        <= column[2:0];
            cell_row_p0  <= row[8:4];
            cell_col_p0  <= column[9:3];
            // ---- stage 1
            glyph_row_p1 <= glyph_row_p0;
            px_p1        <= px_p0;
            cell_row_p1  <= cell_row_p0;
            cell_col_p1  <= cell_col_p0;
            fg_p1        <= charData[10:8];
            bg_p1        <= charData[13:11];
            blink_p1     <= charData[14];
        end
    end

endmodule
